// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared widths and ALU opcode encodings for the datapath
package datapath_pkg;

    localparam int DP_WIDTH    = 16;
    localparam int DP_D_ADDR_W = 8;
    localparam int DP_R_ADDR_W = 4;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_NOT    = 4'd5,
        ALU_SHL    = 4'd6,
        ALU_SHR    = 4'd7,
        ALU_PASS_A = 4'd8,
        ALU_PASS_B = 4'd9
    } alu_op_e;

endpackage

// File: rtl/datapath_if.sv
// rtl/datapath_if.sv - controller-to-datapath control word and debug taps
interface datapath_if
    import datapath_pkg::*;
#(
    parameter int WIDTH    = DP_WIDTH,
    parameter int D_ADDR_W = DP_D_ADDR_W,
    parameter int R_ADDR_W = DP_R_ADDR_W
);
    logic                D_wr;
    logic                RF_s;
    logic                RF_W_en;
    logic [D_ADDR_W-1:0] D_addr;
    logic [R_ADDR_W-1:0] RF_W_addr;
    logic [R_ADDR_W-1:0] RF_A_addr;
    logic [R_ADDR_W-1:0] RF_B_addr;
    logic [3:0]          ALU_sel;

    logic [WIDTH-1:0]    ALU_A_Out;
    logic [WIDTH-1:0]    ALU_B_Out;
    logic [WIDTH-1:0]    ALU_Out;
    logic [WIDTH-1:0]    Mem_Out;
    logic                Zero_Out;

    modport master (
        output D_wr, RF_s, RF_W_en, D_addr, RF_W_addr, RF_A_addr, RF_B_addr, ALU_sel,
        input  ALU_A_Out, ALU_B_Out, ALU_Out, Mem_Out, Zero_Out
    );

    modport slave (
        input  D_wr, RF_s, RF_W_en, D_addr, RF_W_addr, RF_A_addr, RF_B_addr, ALU_sel,
        output ALU_A_Out, ALU_B_Out, ALU_Out, Mem_Out, Zero_Out
    );
endinterface

// File: rtl/datapath_reg_file.sv
// rtl/datapath_reg_file.sv - register file with two combinational read ports and one write port
module datapath_reg_file
    import datapath_pkg::*;
#(
    parameter int WIDTH    = DP_WIDTH,
    parameter int R_ADDR_W = DP_R_ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [R_ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]    wdata,
    input  logic [R_ADDR_W-1:0] a_addr,
    input  logic [R_ADDR_W-1:0] b_addr,
    output logic [WIDTH-1:0]    a_data,
    output logic [WIDTH-1:0]    b_data
);
    logic [WIDTH-1:0] regs [2**R_ADDR_W];

    // reset clears every register and takes priority over a pending write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**R_ADDR_W; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    // no write bypass: a read of the register being written shows the old value
    assign a_data = regs[a_addr];
    assign b_data = regs[b_addr];
endmodule

// File: rtl/datapath.sv
// rtl/datapath.sv - register file, ALU, data RAM and write-back mux of the 16-bit processor
module datapath
    import datapath_pkg::*;
#(
    parameter int WIDTH    = DP_WIDTH,
    parameter int D_ADDR_W = DP_D_ADDR_W,
    parameter int R_ADDR_W = DP_R_ADDR_W
) (
    input  logic      clk,
    input  logic      reset,
    datapath_if.slave bus
);
    logic [WIDTH-1:0] a_data;
    logic [WIDTH-1:0] b_data;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] mem_out;
    logic [WIDTH-1:0] wb_data;
    logic             zero;
    logic [WIDTH-1:0] ram [2**D_ADDR_W];

    // load write-back uses the RAM data registered on the previous edge
    assign wb_data = bus.RF_s ? mem_out : alu_out;

    datapath_reg_file #(
        .WIDTH    (WIDTH),
        .R_ADDR_W (R_ADDR_W)
    ) u_reg_file (
        .clk    (clk),
        .reset  (reset),
        .we     (bus.RF_W_en),
        .waddr  (bus.RF_W_addr),
        .wdata  (wb_data),
        .a_addr (bus.RF_A_addr),
        .b_addr (bus.RF_B_addr),
        .a_data (a_data),
        .b_data (b_data)
    );

    // ALU: results wrap, carry and overflow are not kept
    always_comb begin
        alu_out = '0;
        case (alu_op_e'(bus.ALU_sel))
            ALU_ADD:    alu_out = a_data + b_data;
            ALU_SUB:    alu_out = a_data - b_data;
            ALU_AND:    alu_out = a_data & b_data;
            ALU_OR:     alu_out = a_data | b_data;
            ALU_XOR:    alu_out = a_data ^ b_data;
            ALU_NOT:    alu_out = ~a_data;
            ALU_SHL:    alu_out = {a_data[WIDTH-2:0], 1'b0};
            ALU_SHR:    alu_out = {1'b0, a_data[WIDTH-1:1]};
            ALU_PASS_A: alu_out = a_data;
            ALU_PASS_B: alu_out = b_data;
            default:    alu_out = '0;
        endcase
    end

    // RAM array write; contents survive reset but no write commits during it
    always_ff @(posedge clk) begin
        if (!reset && bus.D_wr) begin
            ram[bus.D_addr] <= a_data;
        end
    end

    // registered read port, returns old data on a same-address write
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_out <= '0;
        end else begin
            mem_out <= ram[bus.D_addr];
        end
    end

    // zero flag tracks only ALU write-backs; loads leave it alone
    always_ff @(posedge clk) begin
        if (reset) begin
            zero <= 1'b0;
        end else if (bus.RF_W_en && !bus.RF_s) begin
            zero <= (alu_out == '0);
        end
    end

    assign bus.ALU_A_Out = a_data;
    assign bus.ALU_B_Out = b_data;
    assign bus.ALU_Out   = alu_out;
    assign bus.Mem_Out   = mem_out;
    assign bus.Zero_Out  = zero;
endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - self-checking bench for datapath against a behavioural model
module tb_datapath;
    import datapath_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic [15:0] rf_m  [16];
    logic [15:0] ram_m [256];
    logic [15:0] mem_m;
    logic        zero_m;

    datapath_if bus ();

    datapath dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int unsigned ua;
        int unsigned ub;
        int unsigned r;
        ua = a;
        ub = b;
        case (op)
            4'd0:    r = (ua + ub) % 65536;
            4'd1:    r = (ua + 65536 - ub) % 65536;
            4'd2:    r = ua & ub;
            4'd3:    r = ua | ub;
            4'd4:    r = ua ^ ub;
            4'd5:    r = 65535 - ua;
            4'd6:    r = (ua * 2) % 65536;
            4'd7:    r = ua / 2;
            4'd8:    r = ua;
            4'd9:    r = ub;
            default: r = 0;
        endcase
        return 16'(r);
    endfunction

    task automatic drive(input logic dwr, input logic rfs, input logic wen, input logic [7:0] daddr,
                         input logic [3:0] wa, input logic [3:0] aa, input logic [3:0] ba, input logic [3:0] sel);
        bus.D_wr      = dwr;
        bus.RF_s      = rfs;
        bus.RF_W_en   = wen;
        bus.D_addr    = daddr;
        bus.RF_W_addr = wa;
        bus.RF_A_addr = aa;
        bus.RF_B_addr = ba;
        bus.ALU_sel   = sel;
        #1;
    endtask

    task automatic commit();
        logic [15:0] a;
        logic [15:0] alu;
        logic [15:0] old_mem;
        a       = rf_m[bus.RF_A_addr];
        alu     = alu_ref(bus.ALU_sel, a, rf_m[bus.RF_B_addr]);
        old_mem = mem_m;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 16; i++) rf_m[i] = 16'h0;
            mem_m  = 16'h0;
            zero_m = 1'b0;
        end else begin
            mem_m = ram_m[bus.D_addr];
            if (bus.D_wr) ram_m[bus.D_addr] = a;
            if (bus.RF_W_en) rf_m[bus.RF_W_addr] = bus.RF_s ? old_mem : alu;
            if (bus.RF_W_en && !bus.RF_s) zero_m = (alu == 16'h0);
        end
        @(negedge clk);
    endtask

    // builds an arbitrary constant in dst from zero using only ALU ops; clobbers r14/r15
    task automatic build_const(input logic [3:0] dst, input logic [15:0] val);
        drive(0, 0, 1, 8'h0, 4'd15, 4'd15, 4'd15, ALU_XOR); commit();
        drive(0, 0, 1, 8'h0, 4'd14, 4'd15, 4'd15, ALU_NOT); commit();
        drive(0, 0, 1, 8'h0, 4'd14, 4'd15, 4'd14, ALU_SUB); commit();
        drive(0, 0, 1, 8'h0, dst, dst, dst, ALU_XOR); commit();
        for (int b = 15; b >= 0; b--) begin
            drive(0, 0, 1, 8'h0, dst, dst, dst, ALU_ADD); commit();
            if (val[b]) begin
                drive(0, 0, 1, 8'h0, dst, dst, 4'd14, ALU_ADD); commit();
            end
        end
    endtask

    task automatic init_ram();
        for (int i = 0; i < 256; i++) begin
            drive(1, 0, 0, 8'(i), 4'd0, 4'd0, 4'd0, ALU_ADD); commit();
        end
        drive(0, 0, 0, 8'h0, 4'd0, 4'd0, 4'd0, ALU_ADD); commit();
    endtask

    task automatic test_reset();
        rst = 1;
        drive(0, 0, 0, 8'h0, 4'd0, 4'd0, 4'd0, ALU_ADD);
        commit(); commit();
        tests++; if (bus.ALU_A_Out !== 16'h0) begin fails++; $display("FAIL reset_a: got %h want 0000", bus.ALU_A_Out); end
        tests++; if (bus.ALU_B_Out !== 16'h0) begin fails++; $display("FAIL reset_b: got %h want 0000", bus.ALU_B_Out); end
        tests++; if (bus.ALU_Out !== 16'h0) begin fails++; $display("FAIL reset_alu: got %h want 0000", bus.ALU_Out); end
        tests++; if (bus.Mem_Out !== 16'h0) begin fails++; $display("FAIL reset_mem: got %h want 0000", bus.Mem_Out); end
        tests++; if (bus.Zero_Out !== 1'b0) begin fails++; $display("FAIL reset_zero: got %b want 0", bus.Zero_Out); end
        rst = 0;
        drive(0, 0, 1, 8'h0, 4'd3, 4'd0, 4'd0, ALU_ADD); commit();
        drive(0, 0, 0, 8'h0, 4'd0, 4'd3, 4'd0, ALU_PASS_A);
        tests++; if (bus.ALU_A_Out !== 16'h0) begin fails++; $display("FAIL rf3_after_add: got %h want 0000", bus.ALU_A_Out); end
        tests++; if (bus.Zero_Out !== 1'b1) begin fails++; $display("FAIL zero_after_add: got %b want 1", bus.Zero_Out); end
        rst = 1;
        drive(0, 0, 1, 8'h0, 4'd3, 4'd0, 4'd0, ALU_NOT); commit();
        rst = 0;
        drive(0, 0, 0, 8'h0, 4'd0, 4'd3, 4'd0, ALU_PASS_A);
        tests++; if (bus.ALU_A_Out !== 16'h0) begin fails++; $display("FAIL write_in_reset: got %h want 0000", bus.ALU_A_Out); end
        tests++; if (bus.Zero_Out !== 1'b0) begin fails++; $display("FAIL zero_mid_reset: got %b want 0", bus.Zero_Out); end
        tests++; if (bus.Mem_Out !== 16'h0) begin fails++; $display("FAIL mem_mid_reset: got %h want 0000", bus.Mem_Out); end
    endtask

    task automatic test_store_load();
        build_const(4'd6, 16'h1234);
        drive(1, 0, 0, 8'h05, 4'd0, 4'd6, 4'd0, ALU_ADD); commit();
        drive(0, 0, 0, 8'h05, 4'd0, 4'd0, 4'd0, ALU_ADD); commit();
        drive(0, 1, 1, 8'h77, 4'd1, 4'd0, 4'd0, ALU_ADD); commit();
        drive(1, 0, 0, 8'h20, 4'd0, 4'd1, 4'd0, ALU_ADD);
        tests++; if (bus.ALU_A_Out !== 16'h1234) begin fails++; $display("FAIL rf1_preload: got %h want 1234", bus.ALU_A_Out); end
        commit();
        drive(0, 0, 0, 8'h20, 4'd0, 4'd0, 4'd0, ALU_ADD); commit();
        drive(0, 1, 1, 8'h99, 4'd2, 4'd0, 4'd0, ALU_ADD);
        tests++; if (bus.Mem_Out !== 16'h1234) begin fails++; $display("FAIL load_mem_out: got %h want 1234", bus.Mem_Out); end
        commit();
        drive(0, 0, 0, 8'h00, 4'd0, 4'd2, 4'd0, ALU_PASS_A);
        tests++; if (bus.ALU_A_Out !== 16'h1234) begin fails++; $display("FAIL rf2_loaded: got %h want 1234", bus.ALU_A_Out); end
    endtask

    task automatic test_reset_mid_store();
        rst = 1;
        drive(1, 0, 0, 8'h30, 4'd0, 4'd6, 4'd0, ALU_ADD); commit();
        rst = 0;
        drive(0, 0, 0, 8'h30, 4'd0, 4'd0, 4'd0, ALU_ADD); commit();
        drive(0, 0, 0, 8'h30, 4'd0, 4'd0, 4'd0, ALU_ADD);
        tests++; if (bus.Mem_Out !== 16'h0) begin fails++; $display("FAIL store_in_reset: got %h want 0000", bus.Mem_Out); end
    endtask

    task automatic test_alu_wrap();
        build_const(4'd1, 16'hFFFF);
        build_const(4'd2, 16'h0001);
        drive(0, 0, 1, 8'h0, 4'd3, 4'd1, 4'd2, ALU_ADD);
        tests++; if (bus.ALU_Out !== 16'h0000) begin fails++; $display("FAIL add_wrap: got %h want 0000", bus.ALU_Out); end
        commit();
        drive(0, 0, 1, 8'h0, 4'd3, 4'd2, 4'd1, ALU_SUB);
        tests++; if (bus.Zero_Out !== 1'b1) begin fails++; $display("FAIL add_zero: got %b want 1", bus.Zero_Out); end
        tests++; if (bus.ALU_Out !== 16'h0002) begin fails++; $display("FAIL sub_wrap: got %h want 0002", bus.ALU_Out); end
        commit();
        drive(0, 0, 0, 8'h0, 4'd0, 4'd3, 4'd0, ALU_PASS_A);
        tests++; if (bus.Zero_Out !== 1'b0) begin fails++; $display("FAIL sub_zero: got %b want 0", bus.Zero_Out); end
        tests++; if (bus.ALU_A_Out !== 16'h0002) begin fails++; $display("FAIL rf3_sub: got %h want 0002", bus.ALU_A_Out); end
    endtask

    task automatic test_shifts();
        build_const(4'd4, 16'h8001);
        drive(0, 0, 0, 8'h0, 4'd0, 4'd4, 4'd0, ALU_SHL);
        tests++; if (bus.ALU_Out !== 16'h0002) begin fails++; $display("FAIL shl: got %h want 0002", bus.ALU_Out); end
        drive(0, 0, 0, 8'h0, 4'd0, 4'd4, 4'd0, ALU_SHR);
        tests++; if (bus.ALU_Out !== 16'h4000) begin fails++; $display("FAIL shr: got %h want 4000", bus.ALU_Out); end
        drive(0, 0, 0, 8'h0, 4'd0, 4'd4, 4'd0, ALU_NOT);
        tests++; if (bus.ALU_Out !== 16'h7FFE) begin fails++; $display("FAIL not: got %h want 7ffe", bus.ALU_Out); end
        drive(0, 0, 0, 8'h0, 4'd0, 4'd4, 4'd4, 4'd12);
        tests++; if (bus.ALU_Out !== 16'h0000) begin fails++; $display("FAIL op12: got %h want 0000", bus.ALU_Out); end
        commit();
    endtask

    task automatic test_read_during_write();
        build_const(4'd7, 16'hAAAA);
        drive(1, 0, 0, 8'h10, 4'd0, 4'd7, 4'd0, ALU_ADD); commit();
        build_const(4'd8, 16'h5555);
        drive(1, 0, 0, 8'h10, 4'd0, 4'd8, 4'd0, ALU_ADD); commit();
        drive(0, 0, 0, 8'h10, 4'd0, 4'd0, 4'd0, ALU_ADD);
        tests++; if (bus.Mem_Out !== 16'hAAAA) begin fails++; $display("FAIL rdw_old: got %h want aaaa", bus.Mem_Out); end
        commit();
        drive(0, 0, 0, 8'h10, 4'd0, 4'd0, 4'd0, ALU_ADD);
        tests++; if (bus.Mem_Out !== 16'h5555) begin fails++; $display("FAIL rdw_new: got %h want 5555", bus.Mem_Out); end
    endtask

    task automatic test_load_r0();
        drive(0, 0, 1, 8'h0, 4'd9, 4'd9, 4'd9, ALU_XOR); commit();
        drive(0, 0, 0, 8'h05, 4'd0, 4'd0, 4'd0, ALU_ADD); commit();
        drive(0, 1, 1, 8'h00, 4'd0, 4'd0, 4'd0, ALU_ADD);
        tests++; if (bus.ALU_A_Out !== 16'h0000) begin fails++; $display("FAIL r0_old: got %h want 0000", bus.ALU_A_Out); end
        commit();
        drive(0, 0, 0, 8'h00, 4'd0, 4'd0, 4'd0, ALU_ADD);
        tests++; if (bus.ALU_A_Out !== 16'h1234) begin fails++; $display("FAIL r0_new: got %h want 1234", bus.ALU_A_Out); end
        tests++; if (bus.Zero_Out !== 1'b1) begin fails++; $display("FAIL load_keeps_zero: got %b want 1", bus.Zero_Out); end
    endtask

    task automatic test_random();
        logic [3:0] aa;
        logic [3:0] ba;
        logic [3:0] sel;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            aa  = 4'($urandom);
            ba  = 4'($urandom);
            sel = 4'($urandom_range(0, 11));
            drive(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)), 4'($urandom), aa, ba, sel);
            tests++; if (bus.ALU_A_Out !== rf_m[aa]) begin fails++; $display("FAIL rand_a: got %h want %h", bus.ALU_A_Out, rf_m[aa]); end
            tests++; if (bus.ALU_B_Out !== rf_m[ba]) begin fails++; $display("FAIL rand_b: got %h want %h", bus.ALU_B_Out, rf_m[ba]); end
            tests++; if (bus.ALU_Out !== alu_ref(sel, rf_m[aa], rf_m[ba])) begin fails++; $display("FAIL rand_alu: op %0d got %h want %h", sel, bus.ALU_Out, alu_ref(sel, rf_m[aa], rf_m[ba])); end
            tests++; if (bus.Mem_Out !== mem_m) begin fails++; $display("FAIL rand_mem: got %h want %h", bus.Mem_Out, mem_m); end
            tests++; if (bus.Zero_Out !== zero_m) begin fails++; $display("FAIL rand_zero: got %b want %b", bus.Zero_Out, zero_m); end
            commit();
        end
        rst = 0;
    endtask

    initial begin
        clk   = 0;
        rst   = 1;
        tests = 0;
        fails = 0;
        for (int i = 0; i < 16; i++) rf_m[i] = 16'h0;
        for (int i = 0; i < 256; i++) ram_m[i] = 16'h0;
        mem_m  = 16'h0;
        zero_m = 1'b0;
        drive(0, 0, 0, 8'h0, 4'd0, 4'd0, 4'd0, ALU_ADD);
        @(negedge clk);
        test_reset();
        init_ram();
        test_store_load();
        test_reset_mid_store();
        test_alu_wrap();
        test_shifts();
        test_read_during_write();
        test_load_r0();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/datapath.md
# datapath

Execution datapath of the 16-bit processor, directly downstream of the controller. It consumes the controller's control word each cycle: D_wr, RF_s, RF_W_en, D_addr, RF_W_addr, RF_A_addr, RF_B_addr and ALU_sel. It holds the register file, the ALU, the data RAM and the write-back mux, and exposes internal values for board-level debug display.

## Interface
- WIDTH, 16, data word width
- D_ADDR_W, 8, data RAM address width (2**D_ADDR_W words)
- R_ADDR_W, 4, register address width (2**R_ADDR_W registers)

- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- D_wr  in  1  data RAM write enable
- RF_s  in  1  write-back select: 1 = RAM read data, 0 = ALU result
- RF_W_en  in  1  register file write enable
- D_addr  in  D_ADDR_W  data RAM address
- RF_W_addr  in  R_ADDR_W  register write address
- RF_A_addr  in  R_ADDR_W  read port A address
- RF_B_addr  in  R_ADDR_W  read port B address
- ALU_sel  in  4  ALU operation
- ALU_A_Out  out  WIDTH  register file port A data
- ALU_B_Out  out  WIDTH  register file port B data
- ALU_Out  out  WIDTH  ALU result
- Mem_Out  out  WIDTH  registered RAM read data
- Zero_Out  out  1  registered zero flag

## Operation
- Register file: 2**R_ADDR_W x WIDTH. Ports A and B are combinational reads. One synchronous write: when RF_W_en, rf[RF_W_addr] <= RF_s ? Mem_Out : ALU_Out. Writes to any address are legal; no hardwired zero register.
- ALU: combinational on A = rf[RF_A_addr] and B = rf[RF_B_addr]. Results wrap modulo 2**WIDTH. Carry, overflow and sign are discarded.
  - 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 NOT A
  - 6 SHL A by 1, zero fill; 7 SHR A by 1, logical; 8 PASS A; 9 PASS B
  - 10-15 output 0
- Zero flag: on any edge with RF_W_en=1 and RF_s=0, Zero_Out <= (ALU_Out == 0). Otherwise it holds.
- Data RAM: 2**D_ADDR_W x WIDTH, single port.
  - Write: when D_wr, ram[D_addr] <= rf[RF_A_addr].
  - Read: Mem_Out <= ram[D_addr] on every edge, regardless of D_wr.
- Reset:
  - all registers, Mem_Out and Zero_Out go to 0.
  - RF_W_en and D_wr are ignored while reset is high.
  - RAM contents are not cleared.

## Timing
- Reset values: ALU_A_Out = ALU_B_Out = ALU_Out = Mem_Out = 0, Zero_Out = 0. The first three are 0 because the registers are 0 and rf 0 + rf 0 = 0 under ADD.
- ALU op: operands and result are valid in the same cycle. The register updates at the end of that cycle (1-cycle latency to visibility on A/B).
- Load: D_addr is presented in cycle N. Mem_Out holds ram[D_addr@N] for all of cycle N+1. The controller asserts RF_s=1 and RF_W_en=1 in cycle N+1, and the register is written at the end of N+1. D_addr in cycle N+1 is don't-care for this load.
- Store: D_wr, D_addr and RF_A_addr are all presented in the same cycle. The RAM is written at the end of that cycle.
- RAM read-during-write to the same address: Mem_Out gets the old data. The new data is visible one edge after the next read.
- RF read-during-write to the same register: A/B show the old value until the edge; no bypass.
- Simultaneous D_wr and RF_W_en: both take effect. RF_s=1 then writes the previous cycle's read data.
- Reset asserted mid-load or mid-store: the pending write is dropped and Mem_Out clears. A RAM write is not committed on that edge.

## Structure
- Package datapath_pkg:
  - alu_op_e enum (4-bit encodings above)
  - WIDTH/D_ADDR_W/R_ADDR_W defaults
- Sub-module reg_file holds the register array, the reset clear and the two read ports.
- The ALU stays as an always_comb case in the top.
- The data RAM is the same style of inferred synchronous RAM already used for data memory.

## Test plan
- Reset, then RF_W_en=1 with RF_W_addr=3 for 1 cycle -> rf[3]=0. Assert reset mid-sequence with RF_W_en=1 -> no write; Zero_Out=0; Mem_Out=0.
- Store/load:
  - preload rf[1]=0x1234 via the RAM path: set ram[5] through the bench, then load.
  - D_wr=1, D_addr=0x20, RF_A_addr=1.
  - next cycle, load D_addr=0x20 into rf[2].
  - -> rf[2]=0x1234.
- ALU wrap, with rf[1]=0xFFFF and rf[2]=0x0001:
  - ADD into rf[3] -> rf[3]=0x0000, Zero_Out=1.
  - SUB rf[2]-rf[1] -> 0x0002, Zero_Out=0.
- Shifts, with rf[4]=0x8001:
  - SHL -> 0x0002.
  - SHR -> 0x4000.
  - NOT -> 0x7FFE.
  - ALU_sel=12 -> ALU_Out=0.
- Read-during-write: ram[0x10]=0xAAAA; D_wr=1 at D_addr=0x10 with rf[A]=0x5555 -> Mem_Out=0xAAAA on the next cycle, 0x5555 one cycle later.
- Load into register 0 while RF_A_addr=0 in the write cycle -> ALU_A_Out shows the old value in that cycle and the new value the next cycle. Zero_Out is unchanged by the load.
